// File: rtl/output_writeback.sv
// ----------------------------------------------------------------------------
// output_writeback
//   Last stage of the convolution datapath. Each result word the core emits is
//   tagged with its (x, y, ch) position, given a packed channel-major external
//   memory address and queued in a small FIFO. The FIFO head is written out
//   over a valid/ready port. The block also counts results, records a sticky
//   overflow when a result is dropped, and reports completion of one output
//   feature map.
//
//   Ports
//     i_clk               clock, all logic on the rising edge
//     i_rst_in            synchronous reset, active-high
//     i_start             one-cycle pulse: latch config, begin a new map
//     i_conv_stride_mode  0: step 1, 1: step 2, 2: step 4, 3: step 1
//     i_base_addr         word address of (x=0, y=0, ch=0)
//     i_output_valid      result present this cycle (no backpressure)
//     i_output_x/y/ch     result position on the output grid
//     i_output_data       result word
//     o_mem_valid         write request (FIFO not empty)
//     i_mem_ready         memory accepts the write when valid && ready
//     o_mem_addr          write address of the FIFO head
//     o_mem_wdata         write data of the FIFO head
//     o_running           high while collecting or draining
//     o_done              high once the map is fully written
//     o_overflow          sticky: a result was dropped on a full FIFO
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | capturing results until the expected count is reached
//   DRAIN | all results seen, emptying the FIFO
//   DONE  | map complete, waiting for the next start
// ----------------------------------------------------------------------------
module output_writeback #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int OUTPUT_NB_CHANNELS = 16,
    parameter int EXT_MEM_HEIGHT     = 1 << 20,
    parameter int FIFO_DEPTH         = 8,
    localparam int AW = $clog2(EXT_MEM_HEIGHT),
    localparam int XW = $clog2(FEATURE_MAP_WIDTH),
    localparam int YW = $clog2(FEATURE_MAP_HEIGHT),
    localparam int CW = $clog2(OUTPUT_NB_CHANNELS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_in,
    input  logic                          i_start,
    input  logic [1:0]                    i_conv_stride_mode,
    input  logic [AW-1:0]                 i_base_addr,
    input  logic                          i_output_valid,
    input  logic [XW-1:0]                 i_output_x,
    input  logic [YW-1:0]                 i_output_y,
    input  logic [CW-1:0]                 i_output_ch,
    input  logic [ACCUMULATION_WIDTH-1:0] i_output_data,
    output logic                          o_mem_valid,
    input  logic                          i_mem_ready,
    output logic [AW-1:0]                 o_mem_addr,
    output logic [ACCUMULATION_WIDTH-1:0] o_mem_wdata,
    output logic                          o_running,
    output logic                          o_done,
    output logic                          o_overflow
);

    localparam int N_MAX = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
    localparam int CNTW  = $clog2(N_MAX + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_shift;
    logic [AW-1:0]           r_base;
    logic [CNTW-1:0]         r_res_cnt;
    logic                    r_overflow;
    logic                    r_running;
    logic                    r_done;

    logic [AW-1:0]           r_addr_q [FIFO_DEPTH];
    logic [ACCUMULATION_WIDTH-1:0] r_data_q [FIFO_DEPTH];
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [PW:0]             r_fifo_cnt;

    logic [1:0]              w_mode_shift;
    logic [CNTW-1:0]         w_n_expected;
    logic [CNTW-1:0]         w_res_next;
    logic [7:0]              w_y_sh;
    logic [7:0]              w_ch_sh;
    logic [AW-1:0]           w_x_ext;
    logic [AW-1:0]           w_y_ext;
    logic [AW-1:0]           w_ch_ext;
    logic [AW-1:0]           w_push_addr;
    logic                    w_start_ok;
    logic                    w_capture;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    // Stride mode 3 is not a real stride; it behaves like step 1.
    always_comb begin
        w_mode_shift = 2'd0;
        case (i_conv_stride_mode)
            2'd1:    w_mode_shift = 2'd1;
            2'd2:    w_mode_shift = 2'd2;
            default: w_mode_shift = 2'd0;
        endcase
    end

    // Each stride step halves both map dimensions, so N shrinks by 4 per step.
    assign w_n_expected = CNTW'(N_MAX) >> {r_shift, 1'b0};
    assign w_res_next   = r_res_cnt + CNTW'(1);

    // Packed channel-major layout: ch stride = OW*OH, y stride = OW.
    // The sum is kept at AW bits so addresses wrap around external memory.
    assign w_y_sh      = 8'(XW) - {6'd0, r_shift};
    assign w_ch_sh     = 8'(XW + YW) - {5'd0, r_shift, 1'b0};
    assign w_x_ext     = AW'(i_output_x);
    assign w_y_ext     = AW'(i_output_y);
    assign w_ch_ext    = AW'(i_output_ch);
    assign w_push_addr = r_base + (w_ch_ext << w_ch_sh) + (w_y_ext << w_y_sh) + w_x_ext;

    assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_capture  = (r_state == S_RUN) && i_output_valid;
    assign w_empty    = (r_fifo_cnt == '0);
    assign w_full     = (r_fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign w_pop      = !w_empty && i_mem_ready;
    // A full FIFO still takes a result when the head leaves in the same cycle.
    assign w_push     = w_capture && (!w_full || w_pop);
    assign w_drop     = w_capture && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst_in) begin
            r_state    <= S_IDLE;
            r_shift    <= 2'd0;
            r_base     <= '0;
            r_res_cnt  <= '0;
            r_overflow <= 1'b0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_shift    <= w_mode_shift;
                        r_base     <= i_base_addr;
                        r_res_cnt  <= '0;
                        r_overflow <= 1'b0;
                        r_running  <= 1'b1;
                        r_done     <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_output_valid) begin
                        // Dropped results still count toward the map total.
                        r_res_cnt <= w_res_next;
                        if (w_drop) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_res_next == w_n_expected) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_in) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (PW+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (PW+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr_q[r_wptr] <= w_push_addr;
            r_data_q[r_wptr] <= i_output_data;
        end
    end

    assign o_mem_valid = !w_empty;
    assign o_mem_addr  = w_empty ? '0 : r_addr_q[r_rptr];
    assign o_mem_wdata = w_empty ? '0 : r_data_q[r_rptr];
    assign o_running   = r_running;
    assign o_done      = r_done;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_output_writeback.sv
// ----------------------------------------------------------------------------
// tb_output_writeback
//   Directed bench for output_writeback on a 16x16 map with 2 output channels
//   and an 8-entry FIFO. Writes seen on the memory port are collected by a
//   monitor and compared against hand-computed address/data lists.
// ----------------------------------------------------------------------------
module tb_output_writeback;

    localparam int AW  = 20;
    localparam int ACW = 32;

    logic            clk;
    logic            i_rst_in;
    logic            i_start;
    logic [1:0]      i_conv_stride_mode;
    logic [AW-1:0]   i_base_addr;
    logic            i_output_valid;
    logic [3:0]      i_output_x;
    logic [3:0]      i_output_y;
    logic [0:0]      i_output_ch;
    logic [ACW-1:0]  i_output_data;
    logic            o_mem_valid;
    logic            i_mem_ready;
    logic [AW-1:0]   o_mem_addr;
    logic [ACW-1:0]  o_mem_wdata;
    logic            o_running;
    logic            o_done;
    logic            o_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0]  cap_addr [$];
    logic [ACW-1:0] cap_data [$];
    logic [AW-1:0]  exp_addr [$];
    logic [ACW-1:0] exp_data [$];

    output_writeback #(
        .ACCUMULATION_WIDTH (32),
        .FEATURE_MAP_WIDTH  (16),
        .FEATURE_MAP_HEIGHT (16),
        .OUTPUT_NB_CHANNELS (2),
        .EXT_MEM_HEIGHT     (1 << 20),
        .FIFO_DEPTH         (8)
    ) dut (
        .i_clk              (clk),
        .i_rst_in           (i_rst_in),
        .i_start            (i_start),
        .i_conv_stride_mode (i_conv_stride_mode),
        .i_base_addr        (i_base_addr),
        .i_output_valid     (i_output_valid),
        .i_output_x         (i_output_x),
        .i_output_y         (i_output_y),
        .i_output_ch        (i_output_ch),
        .i_output_data      (i_output_data),
        .o_mem_valid        (o_mem_valid),
        .i_mem_ready        (i_mem_ready),
        .o_mem_addr         (o_mem_addr),
        .o_mem_wdata        (o_mem_wdata),
        .o_running          (o_running),
        .o_done             (o_done),
        .o_overflow         (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, so at the falling edge
    // valid && ready is exactly what the next rising edge will accept.
    always @(negedge clk) begin
        if (!i_rst_in && o_mem_valid && i_mem_ready) begin
            cap_addr.push_back(o_mem_addr);
            cap_data.push_back(o_mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input int ch, input logic [ACW-1:0] data);
        i_output_valid = 1'b1;
        i_output_x     = 4'(x);
        i_output_y     = 4'(y);
        i_output_ch    = 1'(ch);
        i_output_data  = data;
        step();
        i_output_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [ACW-1:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic pulse_start(input logic [1:0] mode, input logic [AW-1:0] base);
        i_conv_stride_mode = mode;
        i_base_addr        = base;
        i_start            = 1'b1;
        step();
        i_start            = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        i_rst_in = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        i_rst_in = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while (!o_done && i < budget) begin
            step();
            i++;
        end
        check(tag, o_done, 1'b1);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_count"}, cap_addr.size(), exp_addr.size());
        n = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), cap_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), cap_data[i], exp_data[i]);
        end
        cap_addr.delete();
        cap_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    function automatic logic [AW-1:0] addr_s2(input int base, input int idx);
        // 4x4 map, 2 channels: idx = ch*16 + y*4 + x
        return AW'(base + ((idx >> 4) << 4) + (((idx >> 2) & 3) << 2) + (idx & 3));
    endfunction

    initial begin
        i_rst_in = 1'b1;
        i_start = 1'b0;
        i_conv_stride_mode = 2'd0;
        i_base_addr = '0;
        i_output_valid = 1'b0;
        i_output_x = '0;
        i_output_y = '0;
        i_output_ch = '0;
        i_output_data = '0;
        i_mem_ready = 1'b1;

        do_reset(3);
        check("rst_mem_valid", o_mem_valid, 1'b0);
        check("rst_running",   o_running,   1'b0);
        check("rst_done",      o_done,      1'b0);
        check("rst_overflow",  o_overflow,  1'b0);
        check("rst_mem_addr",  o_mem_addr,  '0);

        // results offered in IDLE must be ignored
        for (int i = 0; i < 3; i++) send(i, 0, 0, 32'h5555_0000 + i);
        step();
        check("idle_no_write", cap_addr.size(), 0);
        check("idle_mem_valid", o_mem_valid, 1'b0);

        // ---- map 1: step 4 -> 4x4x2, base 0x100, memory always ready
        pulse_start(2'd2, 20'h100);
        check("t1_running", o_running, 1'b1);
        for (int idx = 0; idx < 32; idx++) begin
            expect_write(addr_s2(32'h100, idx), 32'hA000_0000 + idx);
            if (idx == 10) begin
                // start during RUN: config and count must be left alone
                i_start = 1'b1;
                i_conv_stride_mode = 2'd0;
                i_base_addr = 20'h200;
            end
            send(idx & 3, (idx >> 2) & 3, idx >> 4, 32'hA000_0000 + idx);
            if (idx == 10) begin
                i_start = 1'b0;
                check("t5_cnt_after_start", dut.r_res_cnt, 11);
                check("t5_running", o_running, 1'b1);
            end
        end
        check("t1_not_done_yet", o_done, 1'b0);
        wait_done("t1_done", 20);
        check("t1_ch1y3x2_addr", (cap_addr.size() > 30) ? cap_addr[30] : '0, 20'h11E);
        compare_writes("t1");
        check("t1_overflow", o_overflow, 1'b0);
        check("t1_running_off", o_running, 1'b0);

        // results offered in DONE must be ignored
        for (int i = 0; i < 3; i++) send(i, 1, 1, 32'h6666_0000 + i);
        step();
        check("done_no_write", cap_addr.size(), 0);
        check("done_mem_valid", o_mem_valid, 1'b0);
        check("done_level", o_done, 1'b1);

        // ---- map 2: same config, stalled memory, full FIFO behaviour
        pulse_start(2'd2, 20'h100);
        check("t2_done_clr", o_done, 1'b0);
        check("t2_running", o_running, 1'b1);
        i_mem_ready = 1'b0;
        for (int idx = 0; idx < 8; idx++) begin
            expect_write(addr_s2(32'h100, idx), 32'hB000_0000 + idx);
            send(idx & 3, (idx >> 2) & 3, idx >> 4, 32'hB000_0000 + idx);
        end
        check("t2_full_valid", o_mem_valid, 1'b1);
        check("t2_full_no_ovf", o_overflow, 1'b0);
        check("t2_full_occ", dut.r_fifo_cnt, 8);
        check("t2_head_addr", o_mem_addr, 20'h100);

        // full + push + pop in the same cycle: accepted, no overflow
        i_mem_ready = 1'b1;
        expect_write(addr_s2(32'h100, 8), 32'hB000_0008);
        send(0, 2, 0, 32'hB000_0008);
        i_mem_ready = 1'b0;
        check("t3_no_ovf", o_overflow, 1'b0);
        check("t3_occ", dut.r_fifo_cnt, 8);
        check("t3_one_write", cap_addr.size(), 1);

        // full + push without pop: results 9 and 10 dropped
        send(1, 2, 0, 32'hB000_0009);
        send(2, 2, 0, 32'hB000_000A);
        check("t2_ovf_set", o_overflow, 1'b1);
        check("t2_occ_after_drop", dut.r_fifo_cnt, 8);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_stall_addr", o_mem_addr, 20'h101);
            check("t2_stall_data", o_mem_wdata, 32'hB000_0001);
        end
        check("t2_stall_writes", cap_addr.size(), 1);

        i_mem_ready = 1'b1;
        for (int idx = 11; idx < 32; idx++) begin
            expect_write(addr_s2(32'h100, idx), 32'hB000_0000 + idx);
            send(idx & 3, (idx >> 2) & 3, idx >> 4, 32'hB000_0000 + idx);
        end
        wait_done("t2_done", 30);
        compare_writes("t2");
        check("t2_ovf_sticky", o_overflow, 1'b1);

        // ---- address wrap at the top of external memory, step 1 layout
        do_reset(2);
        check("t4_rst_done", o_done, 1'b0);
        check("t4_rst_ovf", o_overflow, 1'b0);
        pulse_start(2'd0, 20'hFFFFE);
        expect_write(20'h00001, 32'hDEAD_BEEF);
        send(3, 0, 0, 32'hDEAD_BEEF);
        expect_write(20'h0010E, 32'h1234_5678);
        send(0, 1, 1, 32'h1234_5678);
        step();
        step();
        compare_writes("t4");

        // ---- reset with a stalled, overflowed FIFO; mode 3 acts as step 1
        do_reset(1);
        pulse_start(2'd3, 20'h0);
        i_mem_ready = 1'b0;
        for (int k = 0; k < 9; k++) send(k, 2, 1, 32'hC000_0000 + k);
        check("t6_mode3_addr", o_mem_addr, 20'h120);
        check("t6_pre_valid", o_mem_valid, 1'b1);
        check("t6_pre_ovf", o_overflow, 1'b1);
        i_rst_in = 1'b1;
        step();
        check("t6_mem_valid", o_mem_valid, 1'b0);
        check("t6_running", o_running, 1'b0);
        check("t6_done", o_done, 1'b0);
        check("t6_overflow", o_overflow, 1'b0);
        i_rst_in = 1'b0;
        i_mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) send(k, 0, 0, 32'hD000_0000 + k);
        for (int i = 0; i < 5; i++) step();
        check("t6_no_writes", cap_addr.size(), 0);
        check("t6_mem_valid_after", o_mem_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
